// File: rtl/game_sequencer.sv
// game_sequencer: colour-wheel draw and falling-ball game control FSM with registered outputs.
// Define SPEED_RAMP_EN to enable the incr_speed pulse every RAMP_EVERY catches.
module game_sequencer #(
    parameter logic [6:0] BOTTOM_Y  = 7'd110,
    parameter logic [3:0] DRAW_LAST = 4'd15
`ifdef SPEED_RAMP_EN
    ,
    parameter int unsigned RAMP_EVERY = 4
`endif
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       go,
    input  logic [3:0] quad_done,
    input  logic       frame_tick,
    input  logic [3:0] draw_cnt,
    input  logic [6:0] ball_y,
    input  logic [2:0] ball_col,
    input  logic [2:0] bottom_col,
    output logic [3:0] quad_en,
    output logic       en_xc,
    output logic       en_yc,
    output logic       en_c,
    output logic       en_ratediv,
    output logic       en_fif,
    output logic       reset_en,
    output logic       reset_auto,
    output logic       col_sel,
    output logic       new_col_en,
    output logic       game_en,
    output logic       incr_speed,
    output logic [7:0] score,
    output logic       game_over,
    output logic [3:0] state_out
);

    typedef enum logic [3:0] {
        S_INIT    = 4'd0,
        S_WB      = 4'd1,
        S_WG      = 4'd2,
        S_WY      = 4'd3,
        S_WR      = 4'd4,
        S_IDLE    = 4'd5,
        S_NEWBALL = 4'd6,
        S_ERASE   = 4'd7,
        S_WAITF   = 4'd8,
        S_MOVE    = 4'd9,
        S_DRAW    = 4'd10,
        S_CHECK   = 4'd11,
        S_OVER    = 4'd12
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_score, w_score_nxt, w_score_inc;
    logic [3:0] r_quad_en, w_quad_en;
    logic       r_en_xc, r_en_yc, r_en_c, r_en_ratediv, r_en_fif;
    logic       w_en_xc, w_en_yc, w_en_c, w_en_ratediv, w_en_fif;
    logic       r_reset_en, r_reset_auto, r_col_sel, r_new_col_en, r_game_en, r_game_over;
    logic       w_reset_en, w_reset_auto, w_col_sel, w_new_col_en, w_game_en, w_game_over;
    logic       w_catch, w_pass_done;
`ifdef SPEED_RAMP_EN
    logic       r_incr_speed, w_incr_speed;
`endif

    assign w_score_inc = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
    assign w_catch     = (ball_col == bottom_col);
    assign w_pass_done = (draw_cnt == DRAW_LAST);

    // Next state, score update and the output values registered on this edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_score_nxt  = r_score;
        w_quad_en    = 4'b0000;
        w_en_xc      = 1'b0;
        w_en_yc      = 1'b0;
        w_en_c       = 1'b0;
        w_en_ratediv = 1'b0;
        w_en_fif     = 1'b0;
        w_reset_en   = 1'b0;
        w_reset_auto = 1'b0;
        w_col_sel    = 1'b0;
        w_new_col_en = 1'b0;
        w_game_en    = 1'b0;
        w_game_over  = 1'b0;
`ifdef SPEED_RAMP_EN
        w_incr_speed = 1'b0;
`endif
        case (r_state)
            S_INIT: begin
                w_reset_en   = 1'b1;
                w_reset_auto = 1'b1;
                w_state_nxt  = S_WB;
            end
            S_WB: begin
                w_quad_en = 4'b0001;
                if (quad_done[0]) w_state_nxt = S_WG;
            end
            S_WG: begin
                w_quad_en = 4'b0010;
                if (quad_done[1]) w_state_nxt = S_WY;
            end
            S_WY: begin
                w_quad_en = 4'b0100;
                if (quad_done[2]) w_state_nxt = S_WR;
            end
            S_WR: begin
                w_quad_en = 4'b1000;
                if (quad_done[3]) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (go) begin
                    w_game_en   = 1'b1;
                    w_state_nxt = S_NEWBALL;
                end
            end
            S_NEWBALL: begin
                w_game_en    = 1'b1;
                w_new_col_en = 1'b1;
                w_reset_auto = 1'b1;
                w_state_nxt  = S_DRAW;
            end
            S_ERASE: begin
                w_game_en = 1'b1;
                w_en_c    = 1'b1;
                w_en_xc   = 1'b1;
                if (w_pass_done) w_state_nxt = S_MOVE;
            end
            S_DRAW: begin
                w_game_en = 1'b1;
                w_col_sel = 1'b1;
                w_en_c    = 1'b1;
                w_en_xc   = 1'b1;
                if (w_pass_done) begin
                    w_reset_en  = 1'b1;
                    w_state_nxt = S_WAITF;
                end
            end
            S_WAITF: begin
                w_game_en    = 1'b1;
                w_en_ratediv = 1'b1;
                w_en_fif     = 1'b1;
                if (frame_tick) w_state_nxt = S_ERASE;
            end
            S_MOVE: begin
                w_game_en   = 1'b1;
                w_en_yc     = 1'b1;
                w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_game_en = 1'b1;
                if (ball_y < BOTTOM_Y) begin
                    w_state_nxt = S_DRAW;
                end else if (w_catch) begin
                    w_score_nxt = w_score_inc;
                    w_state_nxt = S_NEWBALL;
`ifdef SPEED_RAMP_EN
                    w_incr_speed = (w_score_inc != 8'd0) &&
                                   ((32'(w_score_inc) % RAMP_EVERY) == 32'd0);
`endif
                end else begin
                    w_state_nxt = S_OVER;
                end
            end
            S_OVER: begin
                w_game_over = 1'b1;
                if (go) begin
                    w_score_nxt = 8'd0;
                    w_state_nxt = S_INIT;
                end
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    // State, score and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_INIT;
            r_score      <= 8'd0;
            r_quad_en    <= 4'b0000;
            r_en_xc      <= 1'b0;
            r_en_yc      <= 1'b0;
            r_en_c       <= 1'b0;
            r_en_ratediv <= 1'b0;
            r_en_fif     <= 1'b0;
            r_reset_en   <= 1'b0;
            r_reset_auto <= 1'b0;
            r_col_sel    <= 1'b0;
            r_new_col_en <= 1'b0;
            r_game_en    <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_score      <= w_score_nxt;
            r_quad_en    <= w_quad_en;
            r_en_xc      <= w_en_xc;
            r_en_yc      <= w_en_yc;
            r_en_c       <= w_en_c;
            r_en_ratediv <= w_en_ratediv;
            r_en_fif     <= w_en_fif;
            r_reset_en   <= w_reset_en;
            r_reset_auto <= w_reset_auto;
            r_col_sel    <= w_col_sel;
            r_new_col_en <= w_new_col_en;
            r_game_en    <= w_game_en;
            r_game_over  <= w_game_over;
        end
    end

`ifdef SPEED_RAMP_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_incr_speed <= 1'b0;
        else         r_incr_speed <= w_incr_speed;
    end
    assign incr_speed = r_incr_speed;
`else
    assign incr_speed = 1'b0;
`endif

    assign quad_en    = r_quad_en;
    assign en_xc      = r_en_xc;
    assign en_yc      = r_en_yc;
    assign en_c       = r_en_c;
    assign en_ratediv = r_en_ratediv;
    assign en_fif     = r_en_fif;
    assign reset_en   = r_reset_en;
    assign reset_auto = r_reset_auto;
    assign col_sel    = r_col_sel;
    assign new_col_en = r_new_col_en;
    assign game_en    = r_game_en;
    assign game_over  = r_game_over;
    assign score      = r_score;
    assign state_out  = r_state;

endmodule
